// File: rtl/softmax_exp_sched.sv
// Softmax exp scheduler: buffers one input vector, then time-shares a fixed-latency
// exp core across its elements and streams each result out with index and last flag.
module softmax_exp_sched #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned VEC_LEN     = 8,
    parameter int unsigned IDX_W       = 3,
    parameter int unsigned EXP_LATENCY = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  exp_start,
    output logic [DATA_WIDTH-1:0] exp_x,
    input  logic [DATA_WIDTH-1:0] exp_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_last,
    output logic                  busy
);
    localparam int unsigned TIMER_W = (EXP_LATENCY > 1) ? $clog2(EXP_LATENCY) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(VEC_LEN - 1);
    localparam logic [TIMER_W-1:0] TIMER_END = TIMER_W'(EXP_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] vec_buf [VEC_LEN];
    logic [IDX_W-1:0]      load_cnt;
    logic [IDX_W-1:0]      idx;
    logic [TIMER_W-1:0]    timer;
    logic                  in_hs;
    logic                  out_hs;

    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign out_last = out_valid && (out_idx == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:  if (in_hs && (load_cnt == LAST_IDX)) state_nxt = ST_START;
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT:  if (timer == TIMER_END) state_nxt = ST_EMIT;
            ST_EMIT:  if (out_hs) state_nxt = (idx == LAST_IDX) ? ST_LOAD : ST_START;
            default:  state_nxt = ST_LOAD;
        endcase
    end

    // State-decoded handshake and status outputs
    always_comb begin
        in_ready  = 1'b0;
        exp_start = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_START: exp_start = 1'b1;
            ST_EMIT:  out_valid = 1'b1;
            default:  ;
        endcase
    end

    // Element buffer survives reset; writes are blocked while reset is held
    always_ff @(posedge clk) begin
        if (reset && in_hs) begin
            vec_buf[load_cnt] <= in_data;
        end
    end

    // exp_x is preloaded on entry to START so the operand is valid in the start cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            load_cnt <= '0;
            idx      <= '0;
            timer    <= '0;
            exp_x    <= '0;
            out_data <= '0;
            out_idx  <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_hs) begin
                        if (load_cnt == LAST_IDX) begin
                            load_cnt <= '0;
                            idx      <= '0;
                            exp_x    <= (load_cnt == '0) ? in_data : vec_buf[0];
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                ST_START: timer <= '0;
                ST_WAIT: begin
                    timer <= timer + 1'b1;
                    if (timer == TIMER_END) begin
                        out_data <= exp_y;
                        out_idx  <= idx;
                    end
                end
                ST_EMIT: begin
                    if (out_hs && (idx != LAST_IDX)) begin
                        idx   <= idx + 1'b1;
                        exp_x <= vec_buf[idx + 1'b1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_exp_sched.sv
// Self-checking bench for softmax_exp_sched: table vectors, hand-written corner
// sequences and randomized traffic checked against a queue-based scoreboard.
module tb_softmax_exp_sched;
    localparam int VL = 4;
    localparam int L  = 4;
    localparam int IW = 2;
    localparam int TO = 200;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          exp_start;
    logic [31:0]   exp_x;
    logic [31:0]   exp_y;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          busy;

    softmax_exp_sched #(
        .DATA_WIDTH (32),
        .VEC_LEN    (VL),
        .IDX_W      (IW),
        .EXP_LATENCY(L)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .exp_start(exp_start),
        .exp_x    (exp_x),
        .exp_y    (exp_y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // exp core stub: ~x valid exactly L cycles after the start pulse, garbage otherwise
    int          age = 0;
    logic [31:0] xl  = '0;
    always @(posedge clk) begin
        if (exp_start) begin
            xl  <= exp_x;
            age <= 1;
        end else if (age > 0 && age < 1000) begin
            age <= age + 1;
        end
    end
    assign exp_y = (age == L) ? ~xl : 32'hDEADBEEF;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        int          idx;
        logic        last;
    } res_t;

    typedef struct {
        logic [VL-1:0][31:0] din;
        logic [VL-1:0][31:0] dout;
    } vec_t;

    // Scoreboard: accepted inputs form vectors; a full vector yields VL expected results
    logic [31:0] pend[$];
    res_t        exp_q[$];
    res_t        obs_q[$];
    int          cyc = 0;
    int          last_rise = 0;
    int          start_cnt = 0;
    logic        rst_seen = 1'b0;
    logic        want_start = 1'b0;
    logic        prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            pend.delete();
            exp_q.delete();
            rst_seen   = 1'b1;
            want_start = 1'b0;
            prev_valid = 1'b0;
        end else if (rst_seen) begin
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            chk("exp_start", 32'(exp_start), 32'(want_start));
            if (exp_start) begin
                last_rise = cyc;
                start_cnt++;
                if (exp_q.size() != 0) chk("exp_x", exp_x, ~exp_q[0].data);
            end
            if (out_valid && !prev_valid) chk("valid_latency", cyc - last_rise, L + 1);
            if (!out_valid) chk("last_idle", 32'(out_last), 32'd0);
            want_start = 1'b0;
            if (in_valid && in_ready) begin
                pend.push_back(in_data);
                if (pend.size() == VL) begin
                    for (int i = 0; i < VL; i++) begin
                        res_t r;
                        r.data = ~pend[i];
                        r.idx  = i;
                        r.last = (i == VL - 1);
                        exp_q.push_back(r);
                    end
                    pend.delete();
                    want_start = 1'b1;
                end
            end
            if (out_valid && out_ready) begin
                res_t o;
                o.data = out_data;
                o.idx  = int'(out_idx);
                o.last = out_last;
                obs_q.push_back(o);
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("sb_data", out_data, e.data);
                    chk("sb_idx", 32'(out_idx), 32'(e.idx));
                    chk("sb_last", 32'(out_last), 32'(e.last));
                    if (!e.last) want_start = 1'b1;
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_elem(input logic [31:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < TO) begin
            step();
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'd1, 32'd0);
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [VL-1:0][31:0] d, input bit gap);
        for (int i = 0; i < VL; i++) begin
            if (gap) repeat ($urandom_range(0, 2)) step();
            send_elem(d[i]);
        end
    endtask

    task automatic wait_obs(input int target);
        int n = 0;
        while (obs_q.size() < target && n < TO) begin
            step();
            n++;
        end
        if (obs_q.size() < target) chk("obs_timeout", 32'(obs_q.size()), 32'(target));
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < TO) begin
            step();
            n++;
        end
        if (!out_valid) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_vec(input int base, input vec_t v, input string nm);
        if (obs_q.size() >= base + VL) begin
            for (int i = 0; i < VL; i++) begin
                chk({nm, "_data"}, obs_q[base+i].data, v.dout[i]);
                chk({nm, "_idx"}, 32'(obs_q[base+i].idx), 32'(i));
                chk({nm, "_last"}, 32'(obs_q[base+i].last), 32'(i == VL - 1));
            end
        end
    endtask

    vec_t tbl[2];

    initial begin
        int base;
        int sc;
        int n;
        logic [VL-1:0][31:0] rv;

        tbl[0].din  = {32'h40E00000, 32'hC0400000, 32'h3F800000, 32'h00000000};
        tbl[0].dout = {32'hBF1FFFFF, 32'h3FBFFFFF, 32'hC07FFFFF, 32'hFFFFFFFF};
        tbl[1].din  = {32'hFFFFFFFF, 32'h7F800000, 32'h80000000, 32'h12345678};
        tbl[1].dout = {32'h00000000, 32'h807FFFFF, 32'h7FFFFFFF, 32'hEDCBA987};

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_exp_start", 32'(exp_start), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_exp_x", exp_x, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        reset = 1'b1;

        // Table vectors, no stalls
        out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            base = obs_q.size();
            sc   = start_cnt;
            send_vec(tbl[t].din, 1'b0);
            wait_obs(base + VL);
            check_vec(base, tbl[t], "tbl");
            chk("start_pulses", 32'(start_cnt - sc), 32'(VL));
        end

        // Backpressure held for 7 cycles on idx 1
        out_ready = 1'b0;
        base = obs_q.size();
        send_vec(tbl[0].din, 1'b0);
        wait_valid();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        wait_valid();
        repeat (7) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", out_data, 32'hC07FFFFF);
            chk("bp_idx", 32'(out_idx), 32'd1);
            chk("bp_no_start", 32'(exp_start), 32'd0);
            step();
        end
        out_ready = 1'b1;
        wait_obs(base + VL);
        check_vec(base, tbl[0], "bp");

        // Next vector presented while the current one is still being processed
        base = obs_q.size();
        send_vec(tbl[0].din, 1'b0);
        fork
            send_vec(tbl[1].din, 1'b0);
            wait_obs(base + 2 * VL);
        join
        check_vec(base, tbl[0], "ovl_a");
        check_vec(base + VL, tbl[1], "ovl_b");

        // Reset in WAIT of idx 2 aborts the vector
        base = obs_q.size();
        send_vec(tbl[1].din, 1'b0);
        wait_obs(base + 2);
        n = 0;
        while (!exp_start && n < TO) begin
            step();
            n++;
        end
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_exp_start", 32'(exp_start), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        base = obs_q.size();
        send_vec(tbl[0].din, 1'b0);
        wait_obs(base + VL);
        check_vec(base, tbl[0], "post_abort");

        // Reset with in_valid high accepts nothing
        in_valid = 1'b1;
        in_data  = 32'h11111111;
        reset    = 1'b0;
        step();
        reset    = 1'b1;
        in_valid = 1'b0;
        base = obs_q.size();
        send_vec(tbl[1].din, 1'b0);
        wait_obs(base + VL);
        check_vec(base, tbl[1], "rst_valid");

        // Randomized traffic with input gaps and output stalls
        base = obs_q.size();
        fork
            begin
                for (int v = 0; v < 15; v++) begin
                    for (int i = 0; i < VL; i++) rv[i] = $urandom;
                    send_vec(rv, 1'b1);
                end
            end
            begin
                n = 0;
                while (obs_q.size() < base + 15 * VL && n < 5000) begin
                    out_ready = ($urandom_range(0, 9) < 6);
                    step();
                    n++;
                end
                out_ready = 1'b1;
                chk("rand_count", 32'(obs_q.size() - base), 32'(15 * VL));
            end
        join
        step();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
